// File: rtl/menu_pkg.sv
// Shared mode codes, increment-FSM state encoding and default timing for the menu key controller.
package menu_pkg;

  localparam logic [7:0] MODE_TIME   = 8'd0;
  localparam logic [7:0] MODE_DATE   = 8'd1;
  localparam logic [7:0] MODE_DAY    = 8'd2;
  localparam logic [7:0] MODE_YEAR   = 8'd3;
  localparam logic [7:0] MODE_PERSON = 8'd4;
  localparam logic [7:0] MODE_AREA   = 8'd5;
  localparam logic [7:0] MODE_SCHED  = 8'd6;
  localparam logic [7:0] MODE_HOUR   = 8'd7;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeld   = 2'd1,
    StRepeat = 2'd2
  } inc_state_e;

  // Defaults assume a 50 MHz clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned NUM_MODES_DEF       = 8;
  localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

  function automatic logic mode_has_increment(logic [7:0] sel);
    return (sel == MODE_PERSON) || (sel == MODE_AREA);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, counter debounce, accepted level and press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sample;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer runs through reset so the key level is known when reset drops.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[0], key_ni};
  end

  assign sample = ~sync_q[1];

  // A key held across reset must be seen released before it can produce a press event.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    armed_d = armed_q | ~sample;
    if (sample != state_q) begin
      if (cnt_q == CntMax) begin
        state_d = sample;
        press_d = sample & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/menu_key_controller.sv
// Menu front end: debounced Next/Prev step the mode Selector, Inc drives gated Increment pulses.
// Define AUTO_REPEAT_EN to enable hold-to-repeat; otherwise one Increment per press.
module menu_key_controller
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned NUM_MODES       = NUM_MODES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyNext,
  input  logic       KeyPrev,
  input  logic       KeyInc,
  output logic [7:0] Selector,
  output logic       Increment,
  output logic       ModeChanged
);

  localparam logic [7:0] LastMode = 8'(NUM_MODES - 1);

  logic next_press, prev_press, inc_press, inc_level;
  logic unused_next_level, unused_prev_level;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .key_ni (KeyNext),
    .level_o(unused_next_level),
    .press_o(next_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .key_ni (KeyPrev),
    .level_o(unused_prev_level),
    .press_o(prev_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .key_ni (KeyInc),
    .level_o(inc_level),
    .press_o(inc_press)
  );

  logic [7:0] sel_q, sel_d;
  logic       mode_chg;
  logic       mc_q;
  logic       inc_q;
  logic       fire;
  inc_state_e state_q, state_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] HoldLast = RptW'(REPEAT_DELAY - 2);
  localparam logic [RptW-1:0] RptLast  = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  // Coincident Next and Prev events cancel each other.
  always_comb begin
    sel_d = sel_q;
    if (next_press && !prev_press) begin
      sel_d = (sel_q == LastMode) ? 8'd0 : sel_q + 8'd1;
    end else if (prev_press && !next_press) begin
      sel_d = (sel_q == 8'd0) ? LastMode : sel_q - 8'd1;
    end
  end

  assign mode_chg = (sel_d != sel_q);

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    if (mode_chg) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inc_press) begin
            state_d = StHeld;
            fire    = 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_d = '0;
`endif
          end
        end
        StHeld: begin
          if (!inc_level) begin
            state_d = StIdle;
          end
`ifdef AUTO_REPEAT_EN
          // The press cycle is hold cycle 0, so the first repeat lands REPEAT_DELAY-1 later.
          else if (rpt_cnt_q == HoldLast) begin
            state_d   = StRepeat;
            rpt_cnt_d = '0;
            fire      = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
`endif
        end
`ifdef AUTO_REPEAT_EN
        StRepeat: begin
          if (!inc_level) begin
            state_d = StIdle;
          end else if (rpt_cnt_q == RptLast) begin
            rpt_cnt_d = '0;
            fire      = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_q   <= 8'd0;
      mc_q    <= 1'b0;
      inc_q   <= 1'b0;
      state_q <= StIdle;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      sel_q   <= sel_d;
      mc_q    <= mode_chg;
      inc_q   <= fire & mode_has_increment(sel_q);
      state_q <= state_d;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  assign Selector    = sel_q;
  assign ModeChanged = mc_q;
  assign Increment   = inc_q;

endmodule

// File: tb/tb_menu_key_controller.sv
// Self-checking bench for menu_key_controller with short debounce/repeat timing.
module tb_menu_key_controller;

  localparam int unsigned Deb = 4;
  localparam int unsigned Nm  = 8;
  localparam int unsigned Dly = 20;
  localparam int unsigned Per = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif
  localparam int Gap = 12;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       KeyNext, KeyPrev, KeyInc;
  logic [7:0] Selector;
  logic       Increment, ModeChanged;

  always #5 Clock = ~Clock;

  menu_key_controller #(
    .DEBOUNCE_CYCLES(Deb),
    .NUM_MODES      (Nm),
    .REPEAT_DELAY   (Dly),
    .REPEAT_PERIOD  (Per)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KeyNext    (KeyNext),
    .KeyPrev    (KeyPrev),
    .KeyInc     (KeyInc),
    .Selector   (Selector),
    .Increment  (Increment),
    .ModeChanged(ModeChanged)
  );

  // Key masks: bit0 Next, bit1 Prev, bit2 Inc (1 = pressed).
  typedef struct {
    logic [2:0] keys;
    int         hold;
    int         exp_sel;
    int         exp_mc;
    int         exp_inc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int inc_cnt  = 0;
  int mc_cnt   = 0;
  int cyc      = 0;
  bit inc_prev = 1'b0;
  int inc_ticks[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (Increment) begin
      check("increment_not_back_to_back", int'(inc_prev), 0);
      inc_cnt++;
      inc_ticks.push_back(cyc);
    end
    if (ModeChanged) mc_cnt++;
    inc_prev = Increment;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_keys(input logic [2:0] m);
    KeyNext = ~m[0];
    KeyPrev = ~m[1];
    KeyInc  = ~m[2];
  endtask

  task automatic press(input logic [2:0] m, input int hold, input int gap);
    set_keys(m);
    ticks(hold);
    set_keys(3'b000);
    ticks(gap);
  endtask

  task automatic clear_counts();
    inc_cnt = 0;
    mc_cnt  = 0;
    inc_ticks.delete();
  endtask

  // Pulse offsets relative to the press event: 0, then DELAY-1, then every PERIOD.
  function automatic bit is_pulse(input int o);
    if (o == 0) return 1'b1;
    if (!Auto) return 1'b0;
    return (o >= int'(Dly) - 1) && ((o - (int'(Dly) - 1)) % int'(Per) == 0);
  endfunction

  function automatic int model_pulses(input int hold);
    int n = 0;
    for (int o = 0; o < hold; o++) if (is_pulse(o)) n++;
    return n;
  endfunction

  function automatic int model_step(input int s, input logic [2:0] m);
    if (m[0] && !m[1]) return (s + 1) % int'(Nm);
    if (m[1] && !m[0]) return (s + int'(Nm) - 1) % int'(Nm);
    return s;
  endfunction

  function automatic bit gated(input int s);
    return (s == 4) || (s == 5);
  endfunction

  vec_t vecs[14];
  int   exp_ticks[$];
  int   base;
  int   sel_m;

  initial begin
    vecs[0]  = '{3'b010, 8,  1, 1, 0};
    vecs[1]  = '{3'b010, 8,  0, 1, 0};
    vecs[2]  = '{3'b010, 8,  7, 1, 0};
    vecs[3]  = '{3'b001, 8,  0, 1, 0};
    vecs[4]  = '{3'b100, 10, 0, 0, 0};
    vecs[5]  = '{3'b001, 8,  1, 1, 0};
    vecs[6]  = '{3'b001, 8,  2, 1, 0};
    vecs[7]  = '{3'b001, 8,  3, 1, 0};
    vecs[8]  = '{3'b011, 10, 3, 0, 0};
    vecs[9]  = '{3'b001, 8,  4, 1, 0};
    vecs[10] = '{3'b100, 10, 4, 0, 1};
    vecs[11] = '{3'b100, 25, 4, 0, Auto ? 2 : 1};
    vecs[12] = '{3'b001, 8,  5, 1, 0};
    vecs[13] = '{3'b100, 10, 5, 0, 1};

    Reset = 1'b1;
    set_keys(3'b000);
    ticks(4);
    check("reset_selector", int'(Selector), 0);
    check("reset_increment", int'(Increment), 0);
    check("reset_modechanged", int'(ModeChanged), 0);
    Reset = 1'b0;
    ticks(3);
    check("idle_selector", int'(Selector), 0);

    // Clean press: Selector steps exactly DEBOUNCE_CYCLES+3 cycles after the raw edge.
    clear_counts();
    set_keys(3'b001);
    for (int k = 1; k <= int'(Deb) + 3; k++) begin
      tick();
      check("latency_modechanged", int'(ModeChanged), (k == int'(Deb) + 3) ? 1 : 0);
      check("latency_selector", int'(Selector), (k >= int'(Deb) + 3) ? 1 : 0);
    end
    ticks(10 - (int'(Deb) + 3));
    set_keys(3'b000);
    ticks(Gap);
    check("clean_press_sel", int'(Selector), 1);
    check("clean_press_mc", mc_cnt, 1);

    // Short glitches only: no step.
    clear_counts();
    press(3'b001, 2, 2);
    press(3'b001, 2, Gap);
    check("glitch_sel", int'(Selector), 1);
    check("glitch_mc", mc_cnt, 0);

    // Press with 2-cycle rebounds: exactly one step.
    clear_counts();
    set_keys(3'b001); ticks(8);
    set_keys(3'b000); ticks(2);
    set_keys(3'b001); ticks(2);
    set_keys(3'b000); ticks(2);
    set_keys(3'b001); ticks(8);
    set_keys(3'b000); ticks(Gap);
    check("bounce_sel", int'(Selector), 2);
    check("bounce_mc", mc_cnt, 1);

    for (int i = 0; i < 14; i++) begin
      clear_counts();
      press(vecs[i].keys, vecs[i].hold, Gap);
      check($sformatf("vec%0d_sel", i), int'(Selector), vecs[i].exp_sel);
      check($sformatf("vec%0d_mc", i), mc_cnt, vecs[i].exp_mc);
      check($sformatf("vec%0d_inc", i), inc_cnt, vecs[i].exp_inc);
    end

    // Long hold in AREA: exact pulse cycles.
    clear_counts();
    exp_ticks.delete();
    base = cyc;
    for (int o = 0; o < 60; o++) if (is_pulse(o)) exp_ticks.push_back(base + int'(Deb) + 3 + o);
    press(3'b100, 60, Gap);
    check("hold60_count", inc_ticks.size(), exp_ticks.size());
    for (int i = 0; i < exp_ticks.size(); i++) begin
      if (i < inc_ticks.size()) check($sformatf("hold60_pulse%0d_cycle", i), inc_ticks[i], exp_ticks[i]);
    end

    // Mode change mid-hold (AREA -> PERSON) stops the pulses.
    clear_counts();
    set_keys(3'b100); ticks(25);
    set_keys(3'b110); ticks(6);
    set_keys(3'b100); ticks(49);
    set_keys(3'b000); ticks(Gap);
    check("midhold_sel", int'(Selector), 4);
    check("midhold_mc", mc_cnt, 1);
    check("midhold_inc", inc_cnt, model_pulses(25));
    clear_counts();
    press(3'b100, 10, Gap);
    check("repress_inc", inc_cnt, 1);

    // Reset during a long hold; the held key must be released before it counts again.
    set_keys(3'b100); ticks(40);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset_selector", int'(Selector), 0);
    check("midreset_increment", int'(Increment), 0);
    check("midreset_modechanged", int'(ModeChanged), 0);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      set_keys(3'b101); ticks(8);
      set_keys(3'b100); ticks(Gap);
    end
    ticks(20);
    check("held_after_reset_sel", int'(Selector), 4);
    check("held_after_reset_inc", inc_cnt, 0);
    set_keys(3'b000); ticks(Gap);
    press(3'b100, 10, Gap);
    check("rearm_after_reset_inc", inc_cnt, 1);

    // Wrap-around: eight Next presses return to the start.
    clear_counts();
    for (int i = 0; i < 8; i++) press(3'b001, 6, Gap);
    check("wrap_sel", int'(Selector), 4);
    check("wrap_mc", mc_cnt, 8);

    // Random single-key actions against the model.
    sel_m = 4;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      int         h, e_inc, e_sel;
      case ($urandom_range(0, 2))
        0:       m = 3'b001;
        1:       m = 3'b010;
        default: m = 3'b100;
      endcase
      h     = m[2] ? int'($urandom_range(5, 45)) : int'($urandom_range(5, 12));
      e_inc = (m[2] && gated(sel_m)) ? model_pulses(h) : 0;
      e_sel = model_step(sel_m, m);
      clear_counts();
      press(m, h, Gap);
      check($sformatf("rand%0d_sel", i), int'(Selector), e_sel);
      check($sformatf("rand%0d_mc", i), mc_cnt, (e_sel != sel_m) ? 1 : 0);
      check($sformatf("rand%0d_inc", i), inc_cnt, e_inc);
      sel_m = e_sel;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
